// File: rtl/haz_if.sv
// Issue/writeback/hazard bundle between the decode stage and the hazard scoreboard.
interface haz_if #(
  parameter int REG_W = 4
) ();
  localparam int NUM_REGS = 2 ** REG_W;

  logic                issue_valid;
  logic [REG_W-1:0]    issue_rd;
  logic                issue_wr;
  logic                issue_load;
  logic                issue_flags;
  logic [REG_W-1:0]    src_rs;
  logic [REG_W-1:0]    src_rt;
  logic                rt_used;
  logic                is_br;
  logic                br_reg;
  logic                wb_valid;
  logic [REG_W-1:0]    wb_rd;
  logic                flags_wb;
  logic                stall;
  logic [1:0]          stall_cause;
  logic [NUM_REGS-1:0] pend_mask;
  logic                deadlock;
  logic                protocol_err;
  logic [31:0]         stall_ld_cnt;
  logic [31:0]         stall_br_cnt;

  modport master (
    output issue_valid, issue_rd, issue_wr, issue_load, issue_flags,
           src_rs, src_rt, rt_used, is_br, br_reg, wb_valid, wb_rd, flags_wb,
    input  stall, stall_cause, pend_mask, deadlock, protocol_err,
           stall_ld_cnt, stall_br_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wr, issue_load, issue_flags,
           src_rs, src_rt, rt_used, is_br, br_reg, wb_valid, wb_rd, flags_wb,
    output stall, stall_cause, pend_mask, deadlock, protocol_err,
           stall_ld_cnt, stall_br_cnt
  );
endinterface

// File: rtl/haz_scoreboard.sv
// Register/flag hazard scoreboard: load-use, branch-register and flag stalls with deadlock watchdog.
// Optional stall performance counters are built when HAZ_PERF_CNT_EN is defined.
module haz_scoreboard #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input logic  clk,
  input logic  rst,
  haz_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int CNT_W    = 8;
  localparam logic [NUM_REGS-1:0] ONE    = NUM_REGS'(1);
  localparam logic [CNT_W-1:0]    TO_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]    TO_M1  = CNT_W'(TIMEOUT - 1);

  logic [NUM_REGS-1:0] ldPend, anyPend;
  logic [NUM_REGS-1:0] setMask, clrMask, anyNext, ldNext;
  logic                flagsPend;
  logic [CNT_W-1:0]    waitCnt;
  logic                deadlockQ, protoErrQ;
  logic                loadUse, brRegHaz, flagHaz, stallNow, issueOk;
  logic [1:0]          cause;

  always_comb begin
    loadUse  = ldPend[bus.src_rs] | (bus.rt_used & ldPend[bus.src_rt]);
    brRegHaz = bus.is_br & bus.br_reg & anyPend[bus.src_rs];
    flagHaz  = bus.is_br & ~bus.br_reg & flagsPend;
    stallNow = loadUse | brRegHaz | flagHaz;
    cause    = 2'b00;
    if (loadUse)       cause = 2'b01;
    else if (brRegHaz) cause = 2'b10;
    else if (flagHaz)  cause = 2'b11;
  end

  // Clear is applied before set so an issue retargeting a retiring register keeps it pending.
  always_comb begin
    issueOk = bus.issue_valid & ~stallNow;
    setMask = (issueOk & bus.issue_wr & (bus.issue_rd != '0)) ? (ONE << bus.issue_rd) : '0;
    clrMask = bus.wb_valid ? (ONE << bus.wb_rd) : '0;
    anyNext = ((anyPend & ~clrMask) | setMask) & ~ONE;
    ldNext  = ((ldPend & ~clrMask) | (bus.issue_load ? setMask : '0)) & ~ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldPend    <= '0;
      anyPend   <= '0;
      flagsPend <= 1'b0;
      waitCnt   <= '0;
      deadlockQ <= 1'b0;
      protoErrQ <= 1'b0;
    end else begin
      ldPend    <= ldNext;
      anyPend   <= anyNext;
      flagsPend <= (flagsPend & ~bus.flags_wb) | (issueOk & bus.issue_flags);
      protoErrQ <= protoErrQ | (bus.issue_valid & stallNow);
      if (stallNow) begin
        if (waitCnt != TO_MAX) waitCnt <= waitCnt + 1'b1;
        if (waitCnt >= TO_M1)  deadlockQ <= 1'b1;
      end else begin
        waitCnt <= '0;
      end
    end
  end

  assign bus.stall        = stallNow;
  assign bus.stall_cause  = cause;
  assign bus.pend_mask    = anyPend;
  assign bus.deadlock     = deadlockQ;
  assign bus.protocol_err = protoErrQ;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] ldCnt, brCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldCnt <= '0;
      brCnt <= '0;
    end else begin
      if (cause == 2'b01) ldCnt <= ldCnt + 32'd1;
      if (cause[1])       brCnt <= brCnt + 32'd1;
    end
  end

  assign bus.stall_ld_cnt = ldCnt;
  assign bus.stall_br_cnt = brCnt;
`else
  assign bus.stall_ld_cnt = '0;
  assign bus.stall_br_cnt = '0;
`endif
endmodule

// File: tb/tb_haz_scoreboard.sv
// Scoreboard bench for haz_scoreboard: directed hazard scenarios followed by randomized traffic.
module tb_haz_scoreboard;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 2 ** REG_W;
  localparam int TIMEOUT  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  haz_if #(.REG_W(REG_W)) b ();

  haz_scoreboard #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    bit        stall;
    bit [1:0]  cause;
    bit [15:0] mask;
    bit        dl;
    bit        pe;
    bit [31:0] ldc;
    bit [31:0] brc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: one pending flag per architectural register.
  bit          anyP [NUM_REGS];
  bit          ldP  [NUM_REGS];
  bit          flagsP;
  int          waitC;
  bit          dl, pe;
  int unsigned ldC, brC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall",        32'(b.stall),        32'(e.stall));
      chk("stall_cause",  32'(b.stall_cause),  32'(e.cause));
      chk("pend_mask",    32'(b.pend_mask),    32'(e.mask));
      chk("deadlock",     32'(b.deadlock),     32'(e.dl));
      chk("protocol_err", 32'(b.protocol_err), 32'(e.pe));
      chk("stall_ld_cnt", b.stall_ld_cnt,      e.ldc);
      chk("stall_br_cnt", b.stall_br_cnt,      e.brc);
    end
  end

  task automatic modelClear();
    for (int i = 0; i < NUM_REGS; i++) begin
      anyP[i] = 1'b0;
      ldP[i]  = 1'b0;
    end
    flagsP = 1'b0; waitC = 0; dl = 1'b0; pe = 1'b0; ldC = 0; brC = 0;
  endtask

  task automatic clearIn();
    b.issue_valid = 0; b.issue_rd = '0; b.issue_wr = 0; b.issue_load = 0;
    b.issue_flags = 0; b.src_rs = '0; b.src_rt = '0; b.rt_used = 0;
    b.is_br = 0; b.br_reg = 0; b.wb_valid = 0; b.wb_rd = '0; b.flags_wb = 0;
  endtask

  // One cycle: predict outputs for the inputs now driven, then advance the model at the edge.
  task automatic step();
    exp_t e;
    bit   lu, bs, fs, acc;
    lu = ldP[b.src_rs] || (b.rt_used && ldP[b.src_rt]);
    bs = b.is_br && b.br_reg && anyP[b.src_rs];
    fs = b.is_br && !b.br_reg && flagsP;
    e.stall = lu || bs || fs;
    e.cause = lu ? 2'd1 : bs ? 2'd2 : fs ? 2'd3 : 2'd0;
    for (int i = 0; i < 16; i++) e.mask[i] = (i < NUM_REGS) ? anyP[i] : 1'b0;
    e.dl = dl;
    e.pe = pe;
`ifdef HAZ_PERF_CNT_EN
    e.ldc = ldC;
    e.brc = brC;
`else
    e.ldc = 0;
    e.brc = 0;
`endif
    q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      acc = b.issue_valid && !e.stall;
      if (b.wb_valid) begin
        anyP[b.wb_rd] = 1'b0;
        ldP[b.wb_rd]  = 1'b0;
      end
      if (acc && b.issue_wr && b.issue_rd != 0) begin
        anyP[b.issue_rd] = 1'b1;
        if (b.issue_load) ldP[b.issue_rd] = 1'b1;
      end
      if (b.flags_wb) flagsP = 1'b0;
      if (acc && b.issue_flags) flagsP = 1'b1;
      if (b.issue_valid && e.stall) pe = 1'b1;
      if (e.stall) begin
        if (waitC < TIMEOUT) waitC++;
        if (waitC == TIMEOUT) dl = 1'b1;
      end else begin
        waitC = 0;
      end
      if (e.cause == 2'd1) ldC++;
      if (e.cause >= 2'd2) brC++;
    end
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    clearIn();
    modelClear();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic issueReg(input int rd, input bit ld);
    clearIn();
    b.issue_valid = 1; b.issue_wr = 1; b.issue_load = ld; b.issue_rd = REG_W'(rd);
    step();
    clearIn();
  endtask

  initial begin
    clearIn();
    modelClear();
    @(posedge clk);
    #1;
    doReset(2);

    // Load-use on rs, released by writeback.
    issueReg(3, 1);
    b.src_rs = 3; step();
    b.wb_valid = 1; b.wb_rd = 3; step();
    clearIn(); b.src_rs = 3; step();

    // Store data (rt unused) does not stall; a real rt read does.
    issueReg(5, 1);
    b.src_rt = 5; b.rt_used = 0; step();
    b.rt_used = 1; step();
    clearIn(); b.wb_valid = 1; b.wb_rd = 5; step();

    // Branch on a pending ALU result, and a write to r0.
    issueReg(7, 0);
    b.is_br = 1; b.br_reg = 1; b.src_rs = 7; step();
    clearIn(); b.wb_valid = 1; b.wb_rd = 7; step();
    issueReg(0, 0);
    step();

    // Flag hazard until flag writeback; writeback and reissue of the same register.
    clearIn(); b.issue_valid = 1; b.issue_flags = 1; step();
    clearIn(); b.is_br = 1; b.br_reg = 0; step(); step();
    b.flags_wb = 1; step();
    clearIn(); b.is_br = 1; step();
    issueReg(6, 0);
    b.wb_valid = 1; b.wb_rd = 6; b.issue_valid = 1; b.issue_wr = 1; b.issue_rd = 6; step();
    clearIn(); step();

    // Watchdog, ignored issue during stall, then reset mid-stall.
    doReset(1);
    issueReg(3, 1);
    b.src_rs = 3;
    repeat (TIMEOUT + 1) step();
    b.issue_valid = 1; b.issue_wr = 1; b.issue_rd = 4; step();
    clearIn(); b.src_rs = 3; step(); step();
    rst = 1'b1; clearIn(); b.src_rs = 3; modelClear(); step();
    rst = 1'b0;
    issueReg(4, 0);
    step();

    // Stall cause counters.
    doReset(1);
    issueReg(2, 1);
    b.src_rs = 2; repeat (10) step();
    clearIn(); b.wb_valid = 1; b.wb_rd = 2; step();
    clearIn(); b.issue_valid = 1; b.issue_flags = 1; step();
    clearIn(); b.is_br = 1; b.br_reg = 0; repeat (4) step();
    clearIn(); b.flags_wb = 1; step();
    clearIn(); step(); step();

    // Randomized traffic with occasional resets.
    doReset(1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) doReset($urandom_range(1, 2));
      b.issue_valid = ($urandom_range(0, 1) == 1);
      b.issue_rd    = REG_W'($urandom_range(0, 7));
      b.issue_wr    = ($urandom_range(0, 3) != 0);
      b.issue_load  = ($urandom_range(0, 2) == 0);
      b.issue_flags = ($urandom_range(0, 3) == 0);
      b.src_rs      = REG_W'($urandom_range(0, 7));
      b.src_rt      = REG_W'($urandom_range(0, 7));
      b.rt_used     = ($urandom_range(0, 1) == 1);
      b.is_br       = ($urandom_range(0, 3) == 0);
      b.br_reg      = ($urandom_range(0, 1) == 1);
      b.wb_valid    = ($urandom_range(0, 9) < 4);
      b.wb_rd       = REG_W'($urandom_range(0, 7));
      b.flags_wb    = ($urandom_range(0, 4) == 0);
      step();
    end
    clearIn();

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/haz_scoreboard.md
HAZ_SCOREBOARD -- requirements
Module: haz_scoreboard

Interface
REQ-001 Param REG_W, default 4, register-specifier width; NUM_REGS = 2**REG_W.
REQ-002 Param TIMEOUT, default 255, stall cycles before deadlock flag; CNT_W = 8 holds TIMEOUT.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 issue_valid  input  1  D-stage instruction advances to X this cycle.
REQ-006 issue_rd  input  REG_W  destination of issuing instruction.
REQ-007 issue_wr / issue_load / issue_flags  input  1 each  writes rd / is load / sets flags.
REQ-008 src_rs, src_rt  input  REG_W  D-stage source specifiers; rt_used input 1 (0 for store data, forwarded from MEM).
REQ-009 is_br  input  1  D-stage branch; br_reg input 1 (1 = BR register target, 0 = B on flags).
REQ-010 wb_valid input 1, wb_rd input REG_W  register writeback retires; flags_wb input 1 flag update retires.
REQ-011 stall  output  1;  stall_cause  output  2;  pend_mask  output  NUM_REGS (any-writer pending bits).
REQ-012 deadlock, protocol_err  output  1 each, sticky; stall_ld_cnt, stall_br_cnt  output  32 each.

Function
REQ-013 Two masks: ld_pend (loads in flight), any_pend (any writer in flight); bit 0 never set (r0 hardwired).
REQ-014 Accepted issue (issue_valid & ~stall & issue_wr & issue_rd != 0) sets any_pend[issue_rd], and ld_pend[issue_rd] if issue_load, next edge.
REQ-015 wb_valid clears both bits of wb_rd next edge; same-cycle set and clear of one register: set wins.
REQ-016 flags_pend sets on accepted issue with issue_flags, clears on flags_wb; simultaneous: set wins.
REQ-017 Load-use stall: ld_pend[src_rs] | (rt_used & ld_pend[src_rt]).
REQ-018 Branch-reg stall: is_br & br_reg & any_pend[src_rs]; flag stall: is_br & ~br_reg & flags_pend.
REQ-019 stall = OR of REQ-017/018, combinational from current state, zero-cycle latency.
REQ-020 stall_cause: 00 none, 01 load-use, 10 branch-reg, 11 flags; priority 01 > 10 > 11.
REQ-021 issue_valid while stall=1: issue ignored (no mask update), protocol_err set.
REQ-022 Wait counter (CNT_W) increments each stall cycle, clears on any non-stall cycle, saturates at TIMEOUT; reaching TIMEOUT sets deadlock.
REQ-023 pend_mask equals any_pend, registered.

Reset
REQ-024 rst asserts immediately regardless of clk: masks, flags_pend, wait counter, sticky flags, perf counters all zero; stall=0 unless sources hit (no pending state => 0).
REQ-025 Reset mid-stall drops all pending state; first edge after deassertion accepts issues normally.

Configuration
REQ-026 Macro HAZ_PERF_CNT_EN defined: stall_ld_cnt increments per cycle with cause 01, stall_br_cnt per cycle with cause 10 or 11, wrap at 2**32.
REQ-027 HAZ_PERF_CNT_EN undefined: counters not built, both ports tied to 0; all other behaviour identical.

Verification
REQ-028 Issue load r3; next cycle src_rs=3 -> stall=1, cause=01; wb_valid wb_rd=3 -> stall=0 following cycle.
REQ-029 Load r5 pending, src_rt=5 rt_used=0 (store) -> stall=0; rt_used=1 -> stall=1, cause=01.
REQ-030 ALU write r7 pending, is_br br_reg=1 src_rs=7 -> stall=1, cause=10; issue_rd=0 write -> pend_mask stays 0.
REQ-031 issue_flags accepted, B (br_reg=0) -> cause=11 until flags_wb; wb and new issue same reg same cycle -> bit remains 1.
REQ-032 Hold load-use stall 255 cycles (TIMEOUT=255) -> deadlock=1, sticky; issue_valid during stall -> protocol_err=1, mask unchanged; rst -> all zero.
REQ-033 With HAZ_PERF_CNT_EN, 10 load-use cycles + 4 flag cycles -> stall_ld_cnt=10, stall_br_cnt=4; without macro both 0.
